i2si_ctrl: RTL and testbench

- Sequencer for the I2S input path.
- Starts and stops the deserializer on word-select frame boundaries and selects between live audio and BIST on the input mux.
- Flushes the input FIFO on every stop or mode change, so a half frame or a stale word of the other source never reaches the FIFO.
- Owns the overrun and drop status seen by the register file. Sits between the register file and the synchronizer/deserializer/BIST/mux/FIFO chain.

---
 rtl/i2si_ctrl_pkg.sv | 11 +
 rtl/i2si_ctrl_sat_cnt.sv | 23 ++
 rtl/i2si_ctrl.sv | 121 ++++++++++++
 tb/tb_i2si_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2si_ctrl_pkg.sv
// i2si_ctrl_pkg: state encoding and default sizing for the I2S input sequencer
package i2si_ctrl_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;
    localparam int FLUSH_CYCLES_DEF  = 4;
    localparam int DRAIN_TIMEOUT_DEF = 1024;
    localparam int CNT_W_DEF         = 16;
endpackage

// File: rtl/i2si_ctrl_sat_cnt.sv
// i2si_sat_cnt: counter with clear, increment and optional saturation at all-ones
module i2si_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    input  logic         sat_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;
    // clear wins over history but an increment in the same cycle still counts once
    always_comb begin
        cnt_d = clr_i ? W'(inc_i) : (inc_i && !(sat_i && &cnt_q)) ? cnt_q + W'(1) : cnt_q;
    end
    // count register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/i2si_ctrl.sv
// i2si_ctrl: frame-aligned start/stop, source select, FIFO flush and overrun status for I2S input
module i2si_ctrl
    import i2si_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES  = FLUSH_CYCLES_DEF,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rf_i2si_en,
    input  logic             rf_bist_en,
    input  logic             trig_i2si_fifo_overrun_clr,
    input  logic             ws,
    input  logic             src_xfc,
    input  logic             fifo_inp_rtr,
    output logic             deser_en,
    output logic             bist_run,
    output logic             mux_sel,
    output logic             fifo_flush,
    output logic             ro_fifo_overrun,
    output logic             ro_drain_timeout,
    output logic [CNT_W-1:0] ro_drop_cnt,
    output logic [CNT_W-1:0] ro_frame_cnt,
    output logic [2:0]       ro_state
);
    localparam int TMAX = (DRAIN_TIMEOUT > FLUSH_CYCLES) ? DRAIN_TIMEOUT : FLUSH_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          mode_q, mode_d, ws_q;
    logic          deser_q, deser_d, bist_q, bist_d, flush_q, flush_d;
    logic          ovr_q, ovr_d, to_q, to_d;
    logic          ws_fall, active, drop, drain_to, flush_done, to_exit;

    assign ws_fall    = ws_q & ~ws;
    assign active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign drop       = active & src_xfc & ~fifo_inp_rtr;
    assign drain_to   = tmr_q == TW'(DRAIN_TIMEOUT - 1);
    assign flush_done = tmr_q == TW'(FLUSH_CYCLES - 1);
    // a live drain that runs out of time without seeing the frame boundary
    assign to_exit    = (state_q == ST_DRAIN) & ~mode_q & ~ws_fall & drain_to;

    // sequencer: frame-aligned start, drain to frame end, flush, re-latch requested mode
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                state_d = rf_i2si_en ? ST_ARM : ST_IDLE;
                mode_d  = rf_i2si_en ? rf_bist_en : mode_q;
            end
            ST_ARM:   state_d = !rf_i2si_en ? ST_IDLE : (mode_q || ws_fall) ? ST_RUN : ST_ARM;
            ST_RUN:   state_d = (!rf_i2si_en || rf_bist_en != mode_q) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_d = (mode_q || ws_fall || drain_to) ? ST_FLUSH : ST_DRAIN;
            ST_FLUSH: begin
                state_d = !flush_done ? ST_FLUSH : rf_i2si_en ? ST_ARM : ST_IDLE;
                mode_d  = (flush_done && rf_i2si_en) ? rf_bist_en : mode_q;
            end
            default:  state_d = ST_IDLE;
        endcase
        tmr_d   = (state_d != state_q) ? '0 : tmr_q + TW'(1);
        deser_d = ((state_d == ST_RUN) || (state_d == ST_DRAIN)) & ~mode_d;
        bist_d  = ((state_d == ST_RUN) || (state_d == ST_DRAIN)) & mode_d;
        flush_d = state_d == ST_FLUSH;
        ovr_d   = drop | (ovr_q & ~trig_i2si_fifo_overrun_clr);
        to_d    = to_exit | (to_q & ~trig_i2si_fifo_overrun_clr);
    end

    // state, mode, edge history and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            mode_q  <= 1'b0;
            ws_q    <= 1'b1;
            deser_q <= 1'b0;
            bist_q  <= 1'b0;
            flush_q <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            mode_q  <= mode_d;
            ws_q    <= ws;
            deser_q <= deser_d;
            bist_q  <= bist_d;
            flush_q <= flush_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    i2si_sat_cnt #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (drop),
        .clr_i (trig_i2si_fifo_overrun_clr),
        .sat_i (1'b1),
        .cnt_o (ro_drop_cnt)
    );

    i2si_sat_cnt #(.W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i ((state_q == ST_RUN) & ws_fall),
        .clr_i (1'b0),
        .sat_i (1'b0),
        .cnt_o (ro_frame_cnt)
    );

    assign deser_en         = deser_q;
    assign bist_run         = bist_q;
    assign mux_sel          = mode_q;
    assign fifo_flush       = flush_q;
    assign ro_fifo_overrun  = ovr_q;
    assign ro_drain_timeout = to_q;
    assign ro_state         = state_q;
endmodule

// File: tb/tb_i2si_ctrl.sv
// tb_i2si_ctrl: scenario tasks with randomized timing against a scenario-level reference model
module tb_i2si_ctrl;
    import i2si_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rf_i2si_en, rf_bist_en, trig, ws, src_xfc, fifo_inp_rtr;
    logic        deser_en, bist_run, mux_sel, fifo_flush, ro_fifo_overrun, ro_drain_timeout;
    logic [15:0] ro_drop_cnt, ro_frame_cnt;
    logic [2:0]  ro_state;

    int checks = 0;
    int failures = 0;
    int exp_drop = 0;
    int exp_frames = 0;

    always #5 clk = ~clk;

    i2si_ctrl dut (
        .clk                        (clk),
        .rst                        (rst),
        .rf_i2si_en                 (rf_i2si_en),
        .rf_bist_en                 (rf_bist_en),
        .trig_i2si_fifo_overrun_clr (trig),
        .ws                         (ws),
        .src_xfc                    (src_xfc),
        .fifo_inp_rtr               (fifo_inp_rtr),
        .deser_en                   (deser_en),
        .bist_run                   (bist_run),
        .mux_sel                    (mux_sel),
        .fifo_flush                 (fifo_flush),
        .ro_fifo_overrun            (ro_fifo_overrun),
        .ro_drain_timeout           (ro_drain_timeout),
        .ro_drop_cnt                (ro_drop_cnt),
        .ro_frame_cnt               (ro_frame_cnt),
        .ro_state                   (ro_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_drops(input int n);
        exp_drop = (exp_drop + n > 65535) ? 65535 : exp_drop + n;
    endtask

    task automatic test_reset();
        rst = 1'b0; rf_i2si_en = 1'b0; rf_bist_en = 1'b0; trig = 1'b0;
        ws = 1'b0; src_xfc = 1'b0; fifo_inp_rtr = 1'b1;
        repeat (3) tick();
        checks++;
        if ({deser_en, bist_run, mux_sel, fifo_flush, ro_fifo_overrun, ro_drain_timeout,
             ro_drop_cnt, ro_frame_cnt, ro_state} !== '0)
            begin failures++; $display("FAIL reset_outputs: got state=%0d de=%b br=%b ms=%b ff=%b drop=%0d frame=%0d, want all 0",
                ro_state, deser_en, bist_run, mux_sel, fifo_flush, ro_drop_cnt, ro_frame_cnt); end
        rst = 1'b1;
        repeat (4) tick();
        checks++;
        if (ro_frame_cnt !== 16'd0 || ro_state !== ST_IDLE)
            begin failures++; $display("FAIL reset_release: frame=%0d state=%0d, want 0/0", ro_frame_cnt, ro_state); end
        ws = 1'b1;
        tick();
    endtask

    task automatic start_live();
        int k;
        logic bad;
        bad = 1'b0;
        rf_bist_en = 1'b0; rf_i2si_en = 1'b1; ws = 1'b1;
        tick();
        checks++;
        if (ro_state !== ST_ARM) begin failures++; $display("FAIL live_arm: state=%0d want %0d", ro_state, ST_ARM); end
        k = $urandom_range(3, 20);
        repeat (k) begin
            tick();
            if (ro_state !== ST_ARM || deser_en !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL live_arm_hold: left ARM before ws fall (state=%0d de=%b)", ro_state, deser_en); end
        ws = 1'b0;
        tick();
        checks++;
        if (ro_state !== ST_RUN || deser_en !== 1'b1 || bist_run !== 1'b0 || mux_sel !== 1'b0)
            begin failures++; $display("FAIL live_run: state=%0d de=%b br=%b ms=%b want 2/1/0/0", ro_state, deser_en, bist_run, mux_sel); end
    endtask

    task automatic test_live_frames();
        int n;
        start_live();
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) begin
            ws = 1'b1;
            repeat ($urandom_range(2, 8)) tick();
            ws = 1'b0;
            repeat ($urandom_range(2, 8)) tick();
            exp_frames++;
        end
        checks++;
        if (ro_frame_cnt !== 16'(exp_frames))
            begin failures++; $display("FAIL frame_cnt: got %0d want %0d", ro_frame_cnt, exp_frames); end
    endtask

    task automatic test_drops();
        int n;
        ws = 1'b1; fifo_inp_rtr = 1'b0;
        n = $urandom_range(3, 8);
        for (int i = 0; i < n; i++) begin
            src_xfc = 1'b1; tick(); src_xfc = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        add_drops(n);
        checks++;
        if (ro_drop_cnt !== 16'(exp_drop) || ro_fifo_overrun !== 1'b1)
            begin failures++; $display("FAIL drop_count: got %0d/%b want %0d/1", ro_drop_cnt, ro_fifo_overrun, exp_drop); end
        fifo_inp_rtr = 1'b1; src_xfc = 1'b1; tick(); src_xfc = 1'b0; tick();
        checks++;
        if (ro_drop_cnt !== 16'(exp_drop))
            begin failures++; $display("FAIL accepted_word: got %0d want %0d", ro_drop_cnt, exp_drop); end
        fifo_inp_rtr = 1'b0; src_xfc = 1'b1; trig = 1'b1; tick();
        src_xfc = 1'b0; trig = 1'b0;
        exp_drop = 1;
        checks++;
        if (ro_drop_cnt !== 16'(exp_drop) || ro_fifo_overrun !== 1'b1)
            begin failures++; $display("FAIL clear_with_drop: got %0d/%b want 1/1", ro_drop_cnt, ro_fifo_overrun); end
        trig = 1'b1; tick(); trig = 1'b0;
        exp_drop = 0;
        checks++;
        if (ro_drop_cnt !== 16'd0 || ro_fifo_overrun !== 1'b0 || ro_state !== ST_RUN)
            begin failures++; $display("FAIL clear_alone: got %0d/%b state=%0d want 0/0/2", ro_drop_cnt, ro_fifo_overrun, ro_state); end
    endtask

    task automatic test_drain_timeout();
        int d;
        int f;
        logic bad;
        bad = 1'b0;
        ws = 1'b1; rf_i2si_en = 1'b0;
        tick();
        checks++;
        if (ro_state !== ST_DRAIN || deser_en !== 1'b1)
            begin failures++; $display("FAIL drain_enter: state=%0d de=%b want 3/1", ro_state, deser_en); end
        d = 1;
        fifo_inp_rtr = 1'b0; src_xfc = 1'b1; tick(); src_xfc = 1'b0;
        add_drops(1);
        if (ro_state === ST_DRAIN) d++;
        while (ro_state === ST_DRAIN && d < 2000) begin
            tick();
            if (ro_state === ST_DRAIN) d++;
        end
        checks++;
        if (d != DRAIN_TIMEOUT_DEF) begin failures++; $display("FAIL drain_len: got %0d cycles want %0d", d, DRAIN_TIMEOUT_DEF); end
        checks++;
        if (ro_drop_cnt !== 16'(exp_drop))
            begin failures++; $display("FAIL drain_drop: got %0d want %0d", ro_drop_cnt, exp_drop); end
        f = 0;
        while (ro_state === ST_FLUSH && f < 20) begin
            if (fifo_flush !== 1'b1 || deser_en !== 1'b0) bad = 1'b1;
            f++;
            tick();
        end
        checks++;
        if (f != FLUSH_CYCLES_DEF || bad)
            begin failures++; $display("FAIL flush_len: got %0d cycles bad=%b want %0d", f, bad, FLUSH_CYCLES_DEF); end
        checks++;
        if (ro_state !== ST_IDLE || ro_drain_timeout !== 1'b1 || fifo_flush !== 1'b0)
            begin failures++; $display("FAIL drain_timeout_flag: state=%0d to=%b ff=%b want 0/1/0", ro_state, ro_drain_timeout, fifo_flush); end
        trig = 1'b1; tick(); trig = 1'b0;
        exp_drop = 0;
        checks++;
        if (ro_drain_timeout !== 1'b0 || ro_drop_cnt !== 16'd0)
            begin failures++; $display("FAIL timeout_clear: to=%b drop=%0d want 0/0", ro_drain_timeout, ro_drop_cnt); end
    endtask

    task automatic test_switch_bist();
        int f;
        logic bad;
        bad = 1'b0;
        start_live();
        ws = 1'b1; rf_bist_en = 1'b1;
        tick();
        checks++;
        if (ro_state !== ST_DRAIN || deser_en !== 1'b1)
            begin failures++; $display("FAIL switch_drain: state=%0d de=%b want 3/1", ro_state, deser_en); end
        repeat (9) begin
            tick();
            if (ro_state !== ST_DRAIN) bad = 1'b1;
        end
        ws = 1'b0;
        tick();
        checks++;
        if (bad || ro_state !== ST_FLUSH || deser_en !== 1'b0)
            begin failures++; $display("FAIL switch_flush: bad=%b state=%0d de=%b want 0/4/0", bad, ro_state, deser_en); end
        f = 0; bad = 1'b0;
        while (ro_state === ST_FLUSH && f < 20) begin
            if (mux_sel !== 1'b0 || fifo_flush !== 1'b1) bad = 1'b1;
            f++;
            tick();
        end
        checks++;
        if (f != FLUSH_CYCLES_DEF || bad)
            begin failures++; $display("FAIL switch_flush_len: got %0d bad=%b want %0d", f, bad, FLUSH_CYCLES_DEF); end
        checks++;
        if (ro_state !== ST_ARM || mux_sel !== 1'b1 || bist_run !== 1'b0)
            begin failures++; $display("FAIL bist_arm: state=%0d ms=%b br=%b want 1/1/0", ro_state, mux_sel, bist_run); end
        tick();
        checks++;
        if (ro_state !== ST_RUN || bist_run !== 1'b1 || deser_en !== 1'b0 || ro_drain_timeout !== 1'b0)
            begin failures++; $display("FAIL bist_run: state=%0d br=%b de=%b to=%b want 2/1/0/0", ro_state, bist_run, deser_en, ro_drain_timeout); end
        rf_i2si_en = 1'b0; ws = 1'b1;
        tick();
        tick();
        checks++;
        if (ro_state !== ST_FLUSH || bist_run !== 1'b0)
            begin failures++; $display("FAIL bist_drain_exit: state=%0d br=%b want 4/0", ro_state, bist_run); end
        repeat (FLUSH_CYCLES_DEF) tick();
        checks++;
        if (ro_state !== ST_IDLE) begin failures++; $display("FAIL bist_idle: state=%0d want 0", ro_state); end
    endtask

    task automatic test_saturation_ignored();
        int n;
        int g;
        rf_bist_en = 1'b1; rf_i2si_en = 1'b1;
        tick(); tick();
        checks++;
        if (ro_state !== ST_RUN || bist_run !== 1'b1)
            begin failures++; $display("FAIL sat_run: state=%0d br=%b want 2/1", ro_state, bist_run); end
        fifo_inp_rtr = 1'b0; src_xfc = 1'b1;
        repeat (65540) tick();
        src_xfc = 1'b0;
        add_drops(65540);
        checks++;
        if (ro_drop_cnt !== 16'(exp_drop))
            begin failures++; $display("FAIL drop_saturate: got %h want %h", ro_drop_cnt, 16'(exp_drop)); end
        rf_i2si_en = 1'b0;
        g = 0;
        do begin tick(); g++; end while (ro_state !== ST_IDLE && g < 20);
        checks++;
        if (ro_state !== ST_IDLE) begin failures++; $display("FAIL sat_to_idle: state=%0d want 0", ro_state); end
        trig = 1'b1; tick(); trig = 1'b0;
        exp_drop = 0;
        n = $urandom_range(2, 6);
        repeat (n) begin src_xfc = 1'b1; tick(); src_xfc = 1'b0; tick(); end
        checks++;
        if (ro_drop_cnt !== 16'(exp_drop) || ro_fifo_overrun !== 1'b0)
            begin failures++; $display("FAIL idle_ignored: got %0d/%b want 0/0", ro_drop_cnt, ro_fifo_overrun); end
        fifo_inp_rtr = 1'b1;
    endtask

    task automatic test_reset_mid();
        start_live();
        ws = 1'b1; repeat (3) tick(); ws = 1'b0; repeat (3) tick();
        exp_frames++;
        checks++;
        if (ro_frame_cnt !== 16'(exp_frames))
            begin failures++; $display("FAIL frame_cnt_total: got %0d want %0d", ro_frame_cnt, exp_frames); end
        rst = 1'b0;
        tick();
        exp_frames = 0;
        checks++;
        if ({deser_en, bist_run, mux_sel, fifo_flush, ro_fifo_overrun, ro_drain_timeout, ro_state} !== '0 ||
            ro_frame_cnt !== 16'(exp_frames) || ro_drop_cnt !== 16'd0)
            begin failures++; $display("FAIL mid_reset: state=%0d de=%b ff=%b frame=%0d, want all 0", ro_state, deser_en, fifo_flush, ro_frame_cnt); end
        rf_i2si_en = 1'b0; rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_live_frames();
        test_drops();
        test_drain_timeout();
        test_switch_bist();
        test_saturation_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
